// File: rtl/mcu_el2_dec_trigger_seq_if.sv
// ---------------------------------------------------------------------------
// mcu_el2_dec_trigger_seq_if
// Bundles the decode-side instruction info, the per-trigger configuration
// coming from the TLU trigger CSRs, and the trigger results returned to
// decode/exception logic.
//   master : TLU/decode side. Drives instruction and config signals and
//            receives the results.
//   slave  : trigger unit. Consumes instruction and config signals and
//            drives dec_i0_trigger_match_r and trig_hit.
// Packed per-trigger fields are laid out with trigger i in slice i.
// ---------------------------------------------------------------------------
interface mcu_el2_dec_trigger_seq_if #(
  parameter int NUM_TRIG = 4,
  parameter int CNT_W    = 8
);
  logic                      dec_i0_valid_d;
  logic [31:1]               dec_i0_pc_d;
  logic                      dec_i0_priv_m;
  logic                      dec_flush;
  logic [NUM_TRIG-1:0]       trig_execute;
  logic [NUM_TRIG-1:0]       trig_m;
  logic [2*NUM_TRIG-1:0]     trig_mode;
  logic [NUM_TRIG-1:0]       trig_chain;
  logic [32*NUM_TRIG-1:0]    trig_tdata2;
  logic [NUM_TRIG-1:0]       trig_cnt_ld;
  logic [CNT_W*NUM_TRIG-1:0] trig_thresh;
  logic [NUM_TRIG-1:0]       trig_hit_clr;
  logic [NUM_TRIG-1:0]       dec_i0_trigger_match_r;
  logic [NUM_TRIG-1:0]       trig_hit;

  modport master (
    output dec_i0_valid_d, dec_i0_pc_d, dec_i0_priv_m, dec_flush,
           trig_execute, trig_m, trig_mode, trig_chain, trig_tdata2,
           trig_cnt_ld, trig_thresh, trig_hit_clr,
    input  dec_i0_trigger_match_r, trig_hit
  );

  modport slave (
    input  dec_i0_valid_d, dec_i0_pc_d, dec_i0_priv_m, dec_flush,
           trig_execute, trig_m, trig_mode, trig_chain, trig_tdata2,
           trig_cnt_ld, trig_thresh, trig_hit_clr,
    output dec_i0_trigger_match_r, trig_hit
  );
endinterface

// File: rtl/mcu_el2_dec_trigger_seq.sv
// ---------------------------------------------------------------------------
// mcu_el2_dec_trigger_seq
// Decode-stage PC trigger unit. Each trigger compares the decode PC against
// its tdata2 in one of four modes (exact, NAPOT masked, >=, <). Triggers may
// be chained in even/odd pairs. A per-trigger hit counter swallows a
// programmable number of qualified matches before the trigger starts firing.
// Fires are registered (1-cycle latency) and also set sticky hit status.
//
// Ports:
//   clk    : core clock
//   rst_l  : asynchronous active-low reset
//   bus    : slave modport of mcu_el2_dec_trigger_seq_if (decode info,
//            trigger config, match/hit outputs)
//
// NUM_TRIG must be even (2..8): triggers are processed as chainable pairs.
// ---------------------------------------------------------------------------
module mcu_el2_dec_trigger_seq #(
  parameter int NUM_TRIG = 4,
  parameter int CNT_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst_l,
  mcu_el2_dec_trigger_seq_if.slave     bus
);

  logic [31:0]         w_cmp;
  logic                w_inst_ok;
  logic [NUM_TRIG-1:0] w_raw;
  logic [NUM_TRIG-1:0] w_qual;
  logic [NUM_TRIG-1:0] w_pq;
  logic [NUM_TRIG-1:0] w_fire_raw;
  logic [NUM_TRIG-1:0] w_fire;
  logic [NUM_TRIG-1:0] r_match;
  logic [NUM_TRIG-1:0] r_hit;

  assign w_cmp     = {bus.dec_i0_pc_d, 1'b0};
  // Instruction-level qualifiers common to every trigger; a flush kills the
  // match so nothing downstream (counters, status) sees it.
  assign w_inst_ok = bus.dec_i0_valid_d & bus.dec_i0_priv_m & ~bus.dec_flush;

  // ---------------------------------------------------------------------
  // Per-trigger compare, qualification and hit counter
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_TRIG; gi++) begin : g_trig
    logic [31:0]      w_td;
    logic [1:0]       w_mode;
    logic [31:0]      w_ones;
    logic [31:0]      w_care;
    logic [31:0]      w_td_align;
    logic             w_ld;
    logic [CNT_W-1:0] r_cnt;

    assign w_td       = bus.trig_tdata2[gi*32 +: 32];
    assign w_mode     = bus.trig_mode[gi*2 +: 2];
    assign w_td_align = {w_td[31:1], 1'b0};
    assign w_ld       = bus.trig_cnt_ld[gi];

    // w_ones[j] is set while bits j..0 of tdata2 are all ones. A bit is
    // don't-care when every lower bit is one: that covers the trailing ones
    // plus the first zero above them. Bit 0 is never compared.
    assign w_ones[0] = w_td[0];
    for (genvar gj = 1; gj < 32; gj++) begin : g_ones
      assign w_ones[gj] = w_ones[gj-1] & w_td[gj];
    end
    assign w_care = {~w_ones[30:0], 1'b0};

    always_comb begin
      w_raw[gi] = 1'b0;
      case (w_mode)
        2'd0:    w_raw[gi] = (w_cmp[31:1] == w_td[31:1]);
        2'd1:    w_raw[gi] = (((w_cmp ^ w_td) & w_care) == 32'd0);
        2'd2:    w_raw[gi] = (w_cmp >= w_td_align);
        default: w_raw[gi] = (w_cmp <  w_td_align);
      endcase
    end

    assign w_qual[gi] = w_raw[gi] & bus.trig_execute[gi] & bus.trig_m[gi] & w_inst_ok;

    // Fire only once the skip count is exhausted; a load in the same cycle
    // restarts the count and therefore suppresses the fire.
    assign w_fire_raw[gi] = w_pq[gi] & ~w_ld & (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        r_cnt <= '0;
      end else if (w_ld) begin
        r_cnt <= bus.trig_thresh[gi*CNT_W +: CNT_W];
      end else if (w_pq[gi] && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Pairwise chaining: the even trigger's chain bit binds it to the next
  // odd trigger. Both members must qualify to count, and both must have
  // exhausted their own counters to fire.
  // ---------------------------------------------------------------------
  logic [NUM_TRIG/2-1:0] w_unused_chain_odd;

  for (genvar gi = 0; gi < NUM_TRIG; gi += 2) begin : g_pair
    logic w_chain;
    assign w_chain                  = bus.trig_chain[gi];
    assign w_unused_chain_odd[gi/2] = bus.trig_chain[gi+1];

    assign w_pq[gi]     = w_chain ? (w_qual[gi] & w_qual[gi+1]) : w_qual[gi];
    assign w_pq[gi+1]   = w_chain ? (w_qual[gi] & w_qual[gi+1]) : w_qual[gi+1];
    assign w_fire[gi]   = w_chain ? (w_fire_raw[gi] & w_fire_raw[gi+1]) : w_fire_raw[gi];
    assign w_fire[gi+1] = w_chain ? (w_fire_raw[gi] & w_fire_raw[gi+1]) : w_fire_raw[gi+1];
  end

  // ---------------------------------------------------------------------
  // Registered fire and sticky status (a new fire beats a clear)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_match <= '0;
      r_hit   <= '0;
    end else begin
      r_match <= w_fire;
      r_hit   <= (r_hit & ~bus.trig_hit_clr) | w_fire;
    end
  end

  assign bus.dec_i0_trigger_match_r = r_match;
  assign bus.trig_hit               = r_hit;

endmodule

// File: tb/tb_mcu_el2_dec_trigger_seq.sv
// ---------------------------------------------------------------------------
// tb_mcu_el2_dec_trigger_seq
// Directed bench for the decode PC trigger unit (NUM_TRIG=4, CNT_W=8).
// Inputs change 1 ns after the rising edge; outputs are checked at the same
// point, i.e. after the edge that registered the previous cycle's inputs.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mcu_el2_dec_trigger_seq;
  localparam int NT = 4;
  localparam int CW = 8;

  logic clk;
  logic rst_l;
  int   n_checks;
  int   n_errors;

  mcu_el2_dec_trigger_seq_if #(.NUM_TRIG(NT), .CNT_W(CW)) u_if ();

  mcu_el2_dec_trigger_seq #(.NUM_TRIG(NT), .CNT_W(CW)) u_dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, act);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int idx, input logic [1:0] mode, input logic [31:0] td, input logic en);
    u_if.trig_mode[idx*2 +: 2]     = mode;
    u_if.trig_tdata2[idx*32 +: 32] = td;
    u_if.trig_execute[idx]         = en;
    u_if.trig_m[idx]               = en;
  endtask

  task automatic pc(input logic [31:0] addr);
    u_if.dec_i0_valid_d = 1'b1;
    u_if.dec_i0_pc_d    = addr[31:1];
  endtask

  task automatic match_and_hit(input string tag, input logic [3:0] m, input logic [3:0] h);
    chk({tag, ".match"}, 32'(u_if.dec_i0_trigger_match_r), 32'(m));
    chk({tag, ".hit"},   32'(u_if.trig_hit), 32'(h));
  endtask

  task automatic clear_hits();
    u_if.dec_i0_valid_d = 1'b0;
    u_if.trig_hit_clr   = '1;
    cycle();
    u_if.trig_hit_clr   = '0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_l = 1'b0;
    u_if.dec_i0_valid_d = 1'b0;
    u_if.dec_i0_pc_d    = '0;
    u_if.dec_i0_priv_m  = 1'b1;
    u_if.dec_flush      = 1'b0;
    u_if.trig_execute   = '0;
    u_if.trig_m         = '0;
    u_if.trig_mode      = '0;
    u_if.trig_chain     = '0;
    u_if.trig_tdata2    = '0;
    u_if.trig_cnt_ld    = '0;
    u_if.trig_thresh    = '0;
    u_if.trig_hit_clr   = '0;
    cycle();
    cycle();
    match_and_hit("reset", 4'b0000, 4'b0000);
    rst_l = 1'b1;
    cycle();

    // ---- mode 0 exact ----
    cfg(0, 2'd0, 32'h0000_1000, 1'b1);
    pc(32'h1000);
    cycle();
    match_and_hit("exact_hit", 4'b0001, 4'b0001);
    u_if.dec_i0_valid_d = 1'b0;
    cycle();
    match_and_hit("exact_deassert", 4'b0000, 4'b0001);
    pc(32'h1002);
    cycle();
    chk("exact_miss.match", 32'(u_if.dec_i0_trigger_match_r), 32'h0);
    clear_hits();
    pc(32'h1000);
    u_if.dec_flush = 1'b1;
    cycle();
    match_and_hit("exact_flush", 4'b0000, 4'b0000);
    u_if.dec_flush = 1'b0;

    // ---- mode 1 NAPOT ----
    cfg(0, 2'd1, 32'h0000_10FF, 1'b1);
    pc(32'h1000); cycle();
    chk("napot_1000", 32'(u_if.dec_i0_trigger_match_r), 32'h1);
    pc(32'h11FE); cycle();
    chk("napot_11fe", 32'(u_if.dec_i0_trigger_match_r), 32'h1);
    pc(32'h1200); cycle();
    chk("napot_1200", 32'(u_if.dec_i0_trigger_match_r), 32'h0);
    clear_hits();

    // ---- modes 2/3 and chaining ----
    cfg(0, 2'd2, 32'h0000_2000, 1'b1);
    cfg(1, 2'd3, 32'h0000_3000, 1'b1);
    u_if.trig_chain = 4'b0001;
    pc(32'h2800); cycle();
    chk("chain_2800", 32'(u_if.dec_i0_trigger_match_r), 32'h3);
    pc(32'h3800); cycle();
    chk("chain_3800", 32'(u_if.dec_i0_trigger_match_r), 32'h0);
    pc(32'h1800); cycle();
    chk("chain_1800", 32'(u_if.dec_i0_trigger_match_r), 32'h0);
    u_if.trig_chain = 4'b0000;
    pc(32'h3800); cycle();
    chk("nochain_3800", 32'(u_if.dec_i0_trigger_match_r), 32'h1);
    u_if.trig_chain = 4'b0010;
    pc(32'h3800); cycle();
    chk("oddchain_3800", 32'(u_if.dec_i0_trigger_match_r), 32'h1);
    u_if.trig_chain = 4'b0000;
    pc(32'h3000); cycle();
    chk("ge_lt_eq3000", 32'(u_if.dec_i0_trigger_match_r), 32'h1);
    pc(32'h2000); cycle();
    chk("ge_lt_eq2000", 32'(u_if.dec_i0_trigger_match_r), 32'h3);
    cfg(0, 2'd0, 32'h0, 1'b0);
    cfg(1, 2'd0, 32'h0, 1'b0);
    clear_hits();

    // ---- threshold counter on trigger 2 ----
    cfg(2, 2'd0, 32'h0000_4000, 1'b1);
    u_if.trig_thresh[2*CW +: CW] = 8'd3;
    u_if.trig_cnt_ld = 4'b0100;
    cycle();
    u_if.trig_cnt_ld = 4'b0000;
    pc(32'h4000);
    for (int k = 1; k <= 3; k++) begin
      cycle();
      chk($sformatf("thresh_skip%0d", k), 32'(u_if.dec_i0_trigger_match_r), 32'h0);
    end
    cycle();
    chk("thresh_fire4", 32'(u_if.dec_i0_trigger_match_r), 32'h4);
    cycle();
    chk("thresh_fire5", 32'(u_if.dec_i0_trigger_match_r), 32'h4);
    u_if.trig_cnt_ld = 4'b0100;
    cycle();
    chk("thresh_ld_suppress", 32'(u_if.dec_i0_trigger_match_r), 32'h0);
    u_if.trig_cnt_ld = 4'b0000;
    for (int k = 1; k <= 3; k++) begin
      cycle();
      chk($sformatf("reload_skip%0d", k), 32'(u_if.dec_i0_trigger_match_r), 32'h0);
    end
    cycle();
    chk("reload_fire", 32'(u_if.dec_i0_trigger_match_r), 32'h4);

    // ---- sticky status ----
    u_if.trig_hit_clr = 4'b0100;
    cycle();
    match_and_hit("clr_and_fire", 4'b0100, 4'b0100);
    u_if.dec_i0_valid_d = 1'b0;
    cycle();
    match_and_hit("clr_alone", 4'b0000, 4'b0000);
    u_if.trig_hit_clr = 4'b0000;

    // ---- priv_m gating, all modes ----
    cfg(0, 2'd0, 32'h0000_4000, 1'b1);
    cfg(1, 2'd1, 32'hFFFF_FFFF, 1'b1);
    cfg(2, 2'd2, 32'h0000_0000, 1'b1);
    cfg(3, 2'd3, 32'hFFFF_FFFE, 1'b1);
    u_if.dec_i0_priv_m = 1'b0;
    pc(32'h4000); cycle();
    match_and_hit("priv0", 4'b0000, 4'b0000);
    u_if.dec_i0_priv_m = 1'b1;
    cycle();
    match_and_hit("priv1_all", 4'b1111, 4'b1111);
    clear_hits();

    // ---- asynchronous reset mid-count ----
    cfg(1, 2'd0, 32'h0, 1'b0);
    cfg(3, 2'd0, 32'h0, 1'b0);
    cfg(2, 2'd0, 32'h0000_4000, 1'b1);
    u_if.trig_thresh[2*CW +: CW] = 8'd4;
    u_if.trig_cnt_ld = 4'b0100;
    cycle();
    u_if.trig_cnt_ld = 4'b0000;
    pc(32'h4000);
    cycle();
    cycle();
    match_and_hit("pre_reset", 4'b0001, 4'b0001);
    #2;
    rst_l = 1'b0;
    #1;
    match_and_hit("async_reset", 4'b0000, 4'b0000);
    rst_l = 1'b1;
    cycle();
    match_and_hit("post_reset", 4'b0101, 4'b0101);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mcu_el2_dec_trigger_seq.md
Name: mcu_el2_dec_trigger_seq

Overview:
- Parametrised next-generation decode-stage PC trigger unit for the MCU VeeR EL2 core.
- Supports NUM_TRIG triggers, four match modes (exact, masked NAPOT, >=, <) and pairwise chaining.
- Each trigger has a hit-count threshold; matches are suppressed until the count is exhausted.
- Sits between the TLU trigger CSRs and the decode/exception logic; produces registered, flush-qualified trigger hits and sticky per-trigger hit status.

Parameters:
- NUM_TRIG, 4: number of triggers; must be even, 2..8.
- CNT_W, 8: width of the hit-count threshold and per-trigger counter.

Ports:
- clk  input  1  core clock.
- rst_l  input  1  asynchronous active-low reset.
- dec_i0_valid_d  input  1  i0 instruction valid in decode.
- dec_i0_pc_d  input  31  i0 PC[31:1].
- dec_i0_priv_m  input  1  core in machine mode.
- dec_flush  input  1  decode flush; kills the current decode instruction.
- trig_execute  input  NUM_TRIG  per-trigger execute enable.
- trig_m  input  NUM_TRIG  per-trigger M-mode enable.
- trig_mode  input  2*NUM_TRIG  per-trigger match mode: 0 exact, 1 masked, 2 ge, 3 lt.
- trig_chain  input  NUM_TRIG  chain trigger i to i+1; honoured only for even i.
- trig_tdata2  input  32*NUM_TRIG  per-trigger compare value.
- trig_cnt_ld  input  NUM_TRIG  per-trigger pulse that loads the counter from trig_thresh.
- trig_thresh  input  CNT_W*NUM_TRIG  per-trigger number of qualified matches to skip.
- trig_hit_clr  input  NUM_TRIG  per-trigger clear of sticky hit status.
- dec_i0_trigger_match_r  output  NUM_TRIG  registered trigger fire, one cycle after decode.
- trig_hit  output  NUM_TRIG  sticky hit status.

Behaviour:
- Reset: dec_i0_trigger_match_r=0, trig_hit=0, all counters=0.
- cmp = {dec_i0_pc_d, 1'b0}, unsigned.
- Raw match per trigger i:
  - Mode 0: cmp[31:1]==tdata2[31:1].
  - Mode 1: NAPOT masked compare. The trailing ones of tdata2 plus the next bit are don't-care. Bit 0 is always ignored. tdata2=all ones matches every PC.
  - Mode 2: cmp >= {tdata2[31:1],0}.
  - Mode 3: cmp < {tdata2[31:1],0}.
- Qualification: qual[i] = raw[i] & trig_execute[i] & trig_m[i] & dec_i0_priv_m & dec_i0_valid_d & ~dec_flush.
- Chaining, for even i with trig_chain[i]=1:
  - pq[i] = pq[i+1] = qual[i] & qual[i+1].
  - Otherwise pq = qual.
  - trig_chain on odd i is ignored.
- Counter, one per trigger:
  - trig_cnt_ld[i] loads trig_thresh[i]. Load has priority over decrement in the same cycle.
  - Otherwise, if pq[i] and cnt!=0: cnt decrements and fire[i]=0.
  - If pq[i] and cnt==0: fire[i]=1 and cnt holds at 0.
  - Chained pairs: each member counts independently. The pair fires only when both members' fire terms are set.
- Output register: dec_i0_trigger_match_r <= fire. Latency is exactly 1 cycle. Bits deassert the following cycle unless re-fired.
- Sticky status: trig_hit[i] <= (trig_hit[i] & ~trig_hit_clr[i]) | fire[i]. Set wins over a simultaneous clear.
- Flush: dec_flush in the match cycle gives no fire, no counter change and no status set.
- Config inputs are sampled every cycle. A mode or tdata2 change takes effect on the next qualified instruction, with no restart of counters.
- Reset asserted mid-operation clears counters and outputs asynchronously.

Test Plan:
- Mode 0, tdata2=0x0000_1000, execute=m=1, priv_m=1, PC=0x1000 valid → match_r[0]=1 on the next cycle only; trig_hit[0]=1. Same with dec_flush=1 → 0, trig_hit stays 0.
- Mode 1, tdata2=0x0000_10FF, PCs 0x1000, 0x11FE, 0x1200 → hit, hit, miss.
- Mode 2, tdata2=0x2000 on trigger 0 and mode 3, tdata2=0x3000 on trigger 1, chain[0]=1:
  - PC=0x2800 → both bits set.
  - PC=0x3800 → neither bit set.
  - Chain=0 with PC=0x3800 → bit0 only.
- thresh=3 loaded into trigger 2, PC matching every cycle → no fire for 3 matches, fires on the 4th and every one after. cnt_ld on the 4th cycle reloads the counter and suppresses that fire.
- trig_hit_clr and fire in the same cycle → trig_hit stays 1. Clear alone → 0. priv_m=0 → no fire for any mode.
- Assert rst_l low mid-count (cnt=2) → outputs and counters are 0 asynchronously. After release, a matching PC fires immediately.
